// File: rtl/pe_alu_sequencer.sv
// pe_alu_sequencer: loads a small program over a valid/ready config port,
// then steps through it, driving the PE ALU and writing results to an 8x32 RF.
// Ports: clk, rst_n (async low); cfg_valid/cfg_ready/cfg_data program load;
//   prog_clr, start, busy, done control; alu_in1/alu_in2/alu_en/alu_op to the
//   ALU, alu_out back from it; rf_raddr/rf_rdata debug read; err sticky trap.
// Option: define PE_SEQ_ILLEGAL_OP_TRAP_EN to abort on opcodes 1010..1111
//   (err set, no done); otherwise they retire as NOPs and err stays 0.
module pe_alu_sequencer #(
    parameter int DEPTH = 16,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_valid,
    output logic          cfg_ready,
    input  logic [DW-1:0] cfg_data,
    input  logic          prog_clr,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] alu_in1,
    output logic [DW-1:0] alu_in2,
    output logic          alu_en,
    output logic [3:0]    alu_op,
    input  logic [DW-1:0] alu_out,
    input  logic [2:0]    rf_raddr,
    output logic [DW-1:0] rf_rdata,
    output logic          err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, FETCH, EXEC} state_t;

    state_t state, state_nx;

    logic [AW-1:0] pc;
    logic [AW:0]   wptr;
    logic [DW-1:0] imem [DEPTH];
    logic [DW-1:0] ir;
    logic [DW-1:0] rf [8];
    logic          done_q;
    logic          rf_we;

    logic [12:0] imm13;
    logic [3:0]  op;
    logic [2:0]  rd, rs1, rs2;
    logic        imm_sel, last;
    logic        illegal, last_step, hs;
    logic        unused_bits;

    assign imm13   = ir[31:19];
    assign op      = ir[18:15];
    assign rd      = ir[14:12];
    assign rs1     = ir[11:9];
    assign rs2     = ir[8:6];
    assign imm_sel = ir[5];
    assign last    = ir[4];
    assign unused_bits = &{1'b0, ir[3:0]};

    // 1010..1111 are undefined in the ALU
    assign illegal   = op[3] & (op[2] | op[1]);
    assign last_step = last | (pc == AW'(DEPTH - 1));
    assign hs        = (state == IDLE) & cfg_valid & cfg_ready;

    assign done     = done_q;
    assign rf_rdata = (rf_raddr == 3'd0) ? '0 : rf[rf_raddr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        cfg_ready = 1'b0;
        busy      = 1'b0;
        alu_en    = 1'b0;
        alu_op    = '0;
        alu_in1   = '0;
        alu_in2   = '0;
        rf_we     = 1'b0;
        unique case (state)
            IDLE: begin
                cfg_ready = (wptr < (AW + 1)'(DEPTH));
                if (start) state_nx = FETCH;
            end
            FETCH: begin
                busy     = 1'b1;
                state_nx = EXEC;
            end
            EXEC: begin
                busy    = 1'b1;
                alu_op  = op;
                alu_in1 = rf[rs1];
                alu_in2 = imm_sel ? {{(DW - 13){1'b0}}, imm13} : rf[rs2];
                alu_en  = ~illegal;
                rf_we   = ~illegal & (rd != 3'd0);
`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
                if (illegal || last_step) state_nx = IDLE;
                else                      state_nx = FETCH;
`else
                if (last_step) state_nx = IDLE;
                else           state_nx = FETCH;
`endif
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
    logic err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc     <= '0;
            wptr   <= '0;
            ir     <= '0;
            done_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) imem[i] <= '0;
            for (int i = 0; i < 8; i++) rf[i] <= '0;
`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
            err_q  <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            if (state == IDLE) begin
                // a same-cycle write lands before start takes effect
                if (hs) begin
                    imem[wptr[AW-1:0]] <= cfg_data;
                    wptr <= wptr + (AW + 1)'(1);
                end
                if (prog_clr) wptr <= '0;
                if (start) begin
                    pc <= '0;
`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
                    err_q <= 1'b0;
`endif
                end
            end
            if (state == FETCH) ir <= imem[pc];
            if (state == EXEC) begin
                if (rf_we) rf[rd] <= alu_out;
`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
                if (illegal)        err_q  <= 1'b1;
                else if (last_step) done_q <= 1'b1;
                else                pc     <= pc + AW'(1);
`else
                if (last_step) done_q <= 1'b1;
                else           pc     <= pc + AW'(1);
`endif
            end
        end
    end

endmodule

// File: tb/tb_pe_alu_sequencer.sv
// tb_pe_alu_sequencer: directed bench for pe_alu_sequencer with a small
// behavioural ALU (add/sub/mul/and/or/lt/gt/eq/xor/shl) on alu_out.
module tb_pe_alu_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_valid, cfg_ready;
    logic [31:0] cfg_data;
    logic        prog_clr, start, busy, done;
    logic [31:0] alu_in1, alu_in2, alu_out;
    logic        alu_en;
    logic [3:0]  alu_op;
    logic [2:0]  rf_raddr;
    logic [31:0] rf_rdata;
    logic        err;

    int tests = 0;
    int fails = 0;
    int en_cnt, first_en, done_at, done_cnt;

    always #5 clk = ~clk;

    pe_alu_sequencer #(.DEPTH(16), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_data(cfg_data),
        .prog_clr(prog_clr), .start(start), .busy(busy), .done(done),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_en(alu_en),
        .alu_op(alu_op), .alu_out(alu_out),
        .rf_raddr(rf_raddr), .rf_rdata(rf_rdata), .err(err)
    );

    always_comb begin
        alu_out = 32'd0;
        case (alu_op)
            4'b0000: alu_out = alu_in1 + alu_in2;
            4'b0001: alu_out = alu_in1 - alu_in2;
            4'b0010: alu_out = alu_in1 * alu_in2;
            4'b0011: alu_out = alu_in1 & alu_in2;
            4'b0100: alu_out = alu_in1 | alu_in2;
            4'b0101: alu_out = {31'd0, alu_in1 < alu_in2};
            4'b0110: alu_out = {31'd0, alu_in1 > alu_in2};
            4'b0111: alu_out = {31'd0, alu_in1 == alu_in2};
            4'b1000: alu_out = alu_in1 ^ alu_in2;
            4'b1001: alu_out = alu_in1 << alu_in2[4:0];
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    function automatic logic [31:0] ins(input int imm, input int op,
                                        input int rd, input int rs1,
                                        input int rs2, input bit isel,
                                        input bit lst);
        logic [12:0] i13;
        logic [3:0]  o4;
        logic [2:0]  d3, a3, b3;
        i13 = imm[12:0];
        o4  = op[3:0];
        d3  = rd[2:0];
        a3  = rs1[2:0];
        b3  = rs2[2:0];
        return {i13, o4, d3, a3, b3, isel, lst, 4'b0000};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rd_chk(input string tag, input logic [2:0] a,
                          input logic [31:0] exp);
        rf_raddr = a;
        #1;
        chk(tag, rf_rdata, exp);
    endtask

    task automatic push(input logic [31:0] w);
        cfg_valid = 1'b1;
        cfg_data  = w;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic pulse_clr();
        prog_clr = 1'b1;
        @(negedge clk);
        prog_clr = 1'b0;
    endtask

    // start, then observe a fixed number of cycles; k=1 is the FETCH cycle
    task automatic run(input int ncyc, input bit disturb);
        en_cnt = 0; first_en = 0; done_at = 0; done_cnt = 0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= ncyc; k++) begin
            #1;
            if (alu_en === 1'b1) begin
                en_cnt++;
                if (first_en == 0) first_en = k;
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
            if (disturb && k == 5) begin
                start = 1'b1; cfg_valid = 1'b1; prog_clr = 1'b1;
                cfg_data = ins(77, 0, 7, 0, 0, 1, 1);
            end else begin
                start = 1'b0; cfg_valid = 1'b0; prog_clr = 1'b0;
            end
            @(negedge clk);
        end
        start = 1'b0; cfg_valid = 1'b0; prog_clr = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; cfg_valid = 1'b0; cfg_data = '0;
        prog_clr = 1'b0; start = 1'b0; rf_raddr = '0;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("rst_cfg_ready", {31'd0, cfg_ready}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_alu_en", {31'd0, alu_en}, 32'd0);
        chk("rst_in1", alu_in1, 32'd0);
        chk("rst_in2", alu_in2, 32'd0);
        chk("rst_op", {28'd0, alu_op}, 32'd0);
        chk("rst_err", {31'd0, err}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // basic: r1=5, r2=7, r3=r1*r2
        push(ins(5, 0, 1, 0, 0, 1, 0));
        push(ins(7, 0, 2, 0, 0, 1, 0));
        push(ins(0, 2, 3, 1, 2, 0, 1));
        run(12, 1'b0);
        chk("t1_en_cnt", en_cnt, 32'd3);
        chk("t1_first_en", first_en, 32'd2);
        chk("t1_done_at", done_at, 32'd7);
        chk("t1_done_cnt", done_cnt, 32'd1);
        rd_chk("t1_r1", 3'd1, 32'd5);
        rd_chk("t1_r2", 3'd2, 32'd7);
        rd_chk("t1_r3", 3'd3, 32'd35);

        // compares and a write to r0
        pulse_clr();
        push(ins(3, 0, 1, 0, 0, 1, 0));
        push(ins(9, 0, 2, 0, 0, 1, 0));
        push(ins(0, 5, 4, 1, 2, 0, 0));
        push(ins(0, 6, 5, 1, 2, 0, 0));
        push(ins(0, 7, 6, 1, 2, 0, 0));
        push(ins(5, 0, 0, 1, 0, 1, 1));
        run(16, 1'b0);
        chk("t2_done_cnt", done_cnt, 32'd1);
        rd_chk("t2_lt", 3'd4, 32'd1);
        rd_chk("t2_gt", 3'd5, 32'd0);
        rd_chk("t2_eq", 3'd6, 32'd0);
        rd_chk("t2_r0", 3'd0, 32'd0);

        // fill: 16 x (r7 = r7 + 1), 17th word must be refused
        pulse_clr();
        for (int i = 0; i < 16; i++) begin
            cfg_valid = 1'b1;
            cfg_data  = ins(1, 0, 7, 7, 0, 1, 0);
            if (i == 15) begin
                #1;
                chk("t3_ready_15", {31'd0, cfg_ready}, 32'd1);
            end
            @(negedge clk);
        end
        cfg_valid = 1'b1;
        cfg_data  = ins(100, 0, 7, 0, 0, 1, 1);
        #1;
        chk("t3_full", {31'd0, cfg_ready}, 32'd0);
        @(negedge clk);
        cfg_valid = 1'b0;

        // no last bit: all 16 entries, with ignored pulses mid-run
        run(40, 1'b1);
        chk("t4_en_cnt", en_cnt, 32'd16);
        chk("t4_done_cnt", done_cnt, 32'd1);
        chk("t4_done_at", done_at, 32'd33);
        rd_chk("t4_r7", 3'd7, 32'd16);
        #1;
        chk("t4_clr_ignored", {31'd0, cfg_ready}, 32'd0);
        pulse_clr();
        #1;
        chk("t3_clr_ready", {31'd0, cfg_ready}, 32'd1);
        @(negedge clk);

        // reset during the second EXEC
        push(ins(5, 0, 1, 0, 0, 1, 0));
        push(ins(7, 0, 2, 0, 0, 1, 0));
        push(ins(0, 2, 3, 1, 2, 0, 1));
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("t5_pre_en", {31'd0, alu_en}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t5_en", {31'd0, alu_en}, 32'd0);
        chk("t5_busy", {31'd0, busy}, 32'd0);
        chk("t5_ready", {31'd0, cfg_ready}, 32'd1);
        chk("t5_in1", alu_in1, 32'd0);
        chk("t5_in2", alu_in2, 32'd0);
        chk("t5_op", {28'd0, alu_op}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        rd_chk("t5_r1", 3'd1, 32'd0);
        rd_chk("t5_r7", 3'd7, 32'd0);
        @(negedge clk);

        // illegal op 1100 at pc=1
        push(ins(4, 0, 1, 0, 0, 1, 0));
        push(ins(3, 12, 2, 1, 0, 1, 0));
        push(ins(9, 0, 3, 0, 0, 1, 1));
        run(12, 1'b0);
        rd_chk("t6_r1", 3'd1, 32'd4);
        rd_chk("t6_r2", 3'd2, 32'd0);
`ifdef PE_SEQ_ILLEGAL_OP_TRAP_EN
        chk("t6_err", {31'd0, err}, 32'd1);
        chk("t6_done_cnt", done_cnt, 32'd0);
        chk("t6_en_cnt", en_cnt, 32'd1);
        rd_chk("t6_r3", 3'd3, 32'd0);
`else
        chk("t6_err", {31'd0, err}, 32'd0);
        chk("t6_done_cnt", done_cnt, 32'd1);
        chk("t6_en_cnt", en_cnt, 32'd2);
        rd_chk("t6_r3", 3'd3, 32'd9);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
